fsm_timer_ctrl: RTL



---
 rtl/fsm_timer_pkg.sv | 20 ++
 rtl/fsm_timer_wdog.sv | 40 ++++
 rtl/fsm_timer_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fsm_timer_pkg.sv
// Shared types and constants for the fsm_timer initiator controller.
// Watchdog support is enabled by defining FSM_TIMER_CTRL_WDOG_EN.
package fsm_timer_pkg;

   localparam int unsigned RW_DEF          = 8;
   localparam int unsigned WDOG_CYCLES_DEF = 1024;

   localparam logic HS_ON  = 1'b1;
   localparam logic HS_OFF = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      START_S,
      WAIT,
      ACK,
      SETTLE,
      FIN
   } ctrl_state_t;

endpackage

// File: rtl/fsm_timer_wdog.sv
// WAIT-phase timeout counter: cleared before WAIT, counts WAIT cycles.
// Only instantiated when FSM_TIMER_CTRL_WDOG_EN is defined.
module fsm_timer_wdog
   import fsm_timer_pkg::*;
#(
   parameter int unsigned LIMIT = WDOG_CYCLES_DEF
) (
   input  logic CLK,
   input  logic N_RESET,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The WAIT cycle holding LIMIT-1 is the LIMIT-th one spent waiting.
   assign expired_o = (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fsm_timer_ctrl.sv
// Initiator for the fsm_timer handshake: runs REPS timer intervals per REQ.
// Define FSM_TIMER_CTRL_WDOG_EN to add the WAIT timeout and sticky ERR.
module fsm_timer_ctrl
   import fsm_timer_pkg::*;
#(
   parameter int unsigned RW          = RW_DEF,
   parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic          CLK,
   input  logic          N_RESET,
   input  logic          REQ,
   input  logic [RW-1:0] REPS,
   input  logic          ABORT,
   input  logic          T_READY,
   output logic          T_START,
   output logic          T_RESET,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic [RW-1:0] COUNT
);

   ctrl_state_t   state_q, state_d;
   logic [RW-1:0] reps_q, reps_d;
   logic [RW-1:0] count_q, count_d;
   logic          abort_q, abort_d;
   logic [RW-1:0] count_inc;

   assign count_inc = count_q + RW'(1);

`ifdef FSM_TIMER_CTRL_WDOG_EN
   logic err_q, err_d;
   logic wd_expired;

   fsm_timer_wdog #(
      .LIMIT     (WDOG_CYCLES)
   ) u_wdog (
      .CLK       (CLK),
      .N_RESET   (N_RESET),
      .clr_i     (state_q == START_S),
      .en_i      (state_q == WAIT),
      .expired_o (wd_expired)
   );

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = HS_OFF;
`endif

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state_q <= IDLE;
         reps_q  <= '0;
         count_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         reps_q  <= reps_d;
         count_q <= count_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      reps_d  = reps_q;
      count_d = count_q;
      abort_d = abort_q;
`ifdef FSM_TIMER_CTRL_WDOG_EN
      err_d   = err_q;
`endif
      if (ABORT && state_q != IDLE && state_q != FIN) begin
         abort_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (REQ) begin
               count_d = '0;
               abort_d = 1'b0;
`ifdef FSM_TIMER_CTRL_WDOG_EN
               err_d   = 1'b0;
`endif
               if (REPS != '0) begin
                  reps_d  = REPS;
                  state_d = START_S;
               end else begin
                  state_d = FIN;
               end
            end
         end
         START_S: state_d = WAIT;
         WAIT: begin
            if (T_READY) begin
               state_d = ACK;
`ifdef FSM_TIMER_CTRL_WDOG_EN
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = FIN;
`endif
            end
         end
         ACK: begin
            count_d = count_inc;
            // An abort arriving in this very cycle still ends the run here.
            if (count_inc == reps_q || abort_q || ABORT) begin
               state_d = FIN;
            end else begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (!T_READY) begin
               state_d = START_S;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      T_START = HS_OFF;
      T_RESET = HS_OFF;
      BUSY    = (state_q != IDLE);
      DONE    = 1'b0;
      unique case (state_q)
         START_S: T_START = HS_ON;
         ACK:     T_RESET = HS_ON;
         FIN:     DONE    = 1'b1;
         default: ;
      endcase
   end

   assign COUNT = count_q;

endmodule
